// File: rtl/riscv_cache_pkg.sv
// Shared cache geometry helpers: derive index / word-offset widths from size, line size and ways.
package riscv_cache_pkg;

  // Sets = total bits / (line bits * ways); never narrower than one bit so ports stay legal.
  function automatic int no_of_index_bits(input int size_kb, input int block_size, input int ways);
    int bits;
    bits = $clog2((size_kb * 1024 * 8) / (block_size * ways));
    return (bits < 1) ? 1 : bits;
  endfunction

  function automatic int no_of_data_offset_bits(input int xlen, input int block_size);
    int bits;
    bits = $clog2(block_size / xlen);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/riscv_cache_writebuffer.sv
// Store buffer for the cache write-buffer port: DEPTH-entry FIFO with tail merging,
// drains the head whenever the memories are not read, and flags loads hitting a pending store.
module riscv_cache_writebuffer
  import riscv_cache_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SIZE       = 4,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2,
  parameter int DEPTH      = 4,
  localparam int BE_BITS   = XLEN / 8,
  localparam int IDX_BITS  = no_of_index_bits(SIZE, BLOCK_SIZE, WAYS),
  localparam int OFFS_BITS = no_of_data_offset_bits(XLEN, BLOCK_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [BE_BITS-1:0]   push_be_i,
  input  logic [IDX_BITS-1:0]  push_idx_i,
  input  logic [OFFS_BITS-1:0] push_offs_i,
  input  logic [XLEN-1:0]      push_data_i,
  input  logic [WAYS-1:0]      push_ways_i,
  output logic                 full_o,
  output logic                 empty_o,
  input  logic                 rreq_i,
  output logic                 we_o,
  output logic [BE_BITS-1:0]   be_o,
  output logic [IDX_BITS-1:0]  idx_o,
  output logic [OFFS_BITS-1:0] offs_o,
  output logic [XLEN-1:0]      data_o,
  output logic [WAYS-1:0]      ways_hit_o,
  input  logic [IDX_BITS-1:0]  lkup_idx_i,
  input  logic [OFFS_BITS-1:0] lkup_offs_i,
  output logic                 lkup_hit_o,
  input  logic                 kill_i
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  typedef logic [PTR_BITS-1:0] ptr_t;
  typedef logic [CNT_BITS-1:0] cnt_t;

  typedef struct packed {
    logic [BE_BITS-1:0]   be;
    logic [IDX_BITS-1:0]  idx;
    logic [OFFS_BITS-1:0] offs;
    logic [XLEN-1:0]      data;
    logic [WAYS-1:0]      ways;
  } wb_entry_t;

  wb_entry_t        entries_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  ptr_t             wr_ptr_q, rd_ptr_q;
  cnt_t             count_q;

  ptr_t      tail_ptr;
  wb_entry_t head, tail, merged, incoming;
  logic      pop, merge_ok, do_merge, do_alloc;

  assign head     = entries_q[rd_ptr_q];
  assign tail_ptr = wr_ptr_q - ptr_t'(1);
  assign tail     = entries_q[tail_ptr];
  assign incoming = '{be: push_be_i, idx: push_idx_i, offs: push_offs_i,
                      data: push_data_i, ways: push_ways_i};

  assign we_o       = valid_q[rd_ptr_q];
  assign be_o       = head.be;
  assign idx_o      = head.idx;
  assign offs_o     = head.offs;
  assign data_o     = head.data;
  assign ways_hit_o = head.ways;
  assign empty_o    = (count_q == '0);

  // Same condition the memory uses to commit the write, so retire and write stay in lockstep.
  assign pop = we_o & ~rreq_i;

  // Merging into the head while it is leaving would lose the new bytes.
  assign merge_ok = valid_q[tail_ptr] & ~(pop & (tail_ptr == rd_ptr_q)) &
                    (tail.idx == push_idx_i) & (tail.offs == push_offs_i) &
                    (tail.ways == push_ways_i);

  assign full_o   = (count_q == cnt_t'(DEPTH)) & ~merge_ok;
  assign do_merge = push_i & merge_ok;
  assign do_alloc = push_i & ~merge_ok & ~full_o;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    merged      = tail;
    merged.be   = tail.be | push_be_i;
    lkup_hit_o  = 1'b0;
    for (int b = 0; b < BE_BITS; b++) begin
      if (push_be_i[b]) merged.data[8*b +: 8] = push_data_i[8*b +: 8];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && entries_q[i].idx == lkup_idx_i && entries_q[i].offs == lkup_offs_i)
        lkup_hit_o = 1'b1;
    end
  end

  // NOTE: storage is reset too: it is only DEPTH flops deep and the head outputs must read 0 after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (kill_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + ptr_t'(1);
      end
      if (do_merge) entries_q[tail_ptr] <= merged;
      if (do_alloc) begin
        entries_q[wr_ptr_q] <= incoming;
        valid_q[wr_ptr_q]   <= 1'b1;
        wr_ptr_q            <= wr_ptr_q + ptr_t'(1);
      end
      case ({do_alloc, pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
